// File: rtl/amci_cmd_sequencer_if.sv
// amci_cmd_sequencer_if: AMCI request/response bundle; master = sequencer, slave = axi4_lite_master side
interface amci_cmd_sequencer_if;
  logic [31:0] AMCI_WADDR;
  logic [31:0] AMCI_WDATA;
  logic        AMCI_WRITE;
  logic [1:0]  AMCI_WRESP;
  logic        AMCI_WIDLE;
  logic [31:0] AMCI_RADDR;
  logic        AMCI_READ;
  logic [31:0] AMCI_RDATA;
  logic [1:0]  AMCI_RRESP;
  logic        AMCI_RIDLE;
  modport master (
    output AMCI_WADDR, AMCI_WDATA, AMCI_WRITE, AMCI_RADDR, AMCI_READ,
    input  AMCI_WRESP, AMCI_WIDLE, AMCI_RDATA, AMCI_RRESP, AMCI_RIDLE
  );
  modport slave (
    input  AMCI_WADDR, AMCI_WDATA, AMCI_WRITE, AMCI_RADDR, AMCI_READ,
    output AMCI_WRESP, AMCI_WIDLE, AMCI_RDATA, AMCI_RRESP, AMCI_RIDLE
  );
endinterface

// File: rtl/amci_cmd_sequencer.sv
// amci_cmd_sequencer: table-driven WRITE/READ/POLL/DELAY/END engine; ports clk, reset, start, load_* (table), busy/done/error/err_code/err_idx/rdata_last (status), amci (AMCI master)
module amci_cmd_sequencer #(
  parameter int DEPTH = 16,
  parameter int POLL_MAX = 1000,
  parameter int STOP_ERR = 1,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [2:0]       load_op,
  input  logic [31:0]      load_addr,
  input  logic [31:0]      load_data,
  input  logic [31:0]      load_mask,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [IDX_W-1:0] err_idx,
  output logic [31:0]      rdata_last,
  amci_cmd_sequencer_if.master amci
);
  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam logic [CNT_W-1:0] PMAX = CNT_W'(POLL_MAX);
  localparam logic [2:0] OP_WR = 3'd1, OP_RD = 3'd2, OP_POLL = 3'd3, OP_DLY = 3'd4;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, ARM, WAIT, DELAY, FINISH} state_t;
  state_t state_q;
  logic [2:0] op_t [DEPTH];
  logic [31:0] addr_t [DEPTH];
  logic [31:0] data_t [DEPTH];
  logic [31:0] mask_t [DEPTH];
  logic [IDX_W-1:0] idx_q, eidx_q;
  logic [2:0] op_q;
  logic [31:0] addr_q, data_q, mask_q, cnt_q, rlast_q;
  logic [CNT_W-1:0] att_q;
  logic busy_q, done_q, error_q, write_q, read_q;
  logic [1:0] code_q;
  logic is_wr, idle_ok, resp_bad, hit, timeout, retry, fail, stop;
  logic [2:0] f_op;
  logic [31:0] f_data;
  always_comb begin
    f_op = op_t[idx_q];
    f_data = data_t[idx_q];
    is_wr = op_q == OP_WR;
    idle_ok = is_wr ? amci.AMCI_WIDLE : amci.AMCI_RIDLE;
    resp_bad = is_wr ? amci.AMCI_WRESP != 2'b00 : amci.AMCI_RRESP != 2'b00;
    hit = ((amci.AMCI_RDATA ^ data_q) & mask_q) == 32'd0;
    timeout = op_q == OP_POLL && !resp_bad && !hit && att_q >= PMAX;
    retry = op_q == OP_POLL && !resp_bad && !hit && att_q < PMAX;
    fail = resp_bad || timeout;
    stop = idx_q == IDX_W'(DEPTH - 1) || (STOP_ERR != 0 && state_q == WAIT && fail);
  end
  always_ff @(posedge clk)
    if (load_en && !busy_q) begin
      op_t[load_idx] <= load_op;
      addr_t[load_idx] <= load_addr;
      data_t[load_idx] <= load_data;
      mask_t[load_idx] <= load_mask;
    end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      op_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
      att_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      code_q <= '0;
      eidx_q <= '0;
      rlast_q <= '0;
      write_q <= 1'b0;
      read_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      write_q <= 1'b0;
      read_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          idx_q <= '0;
          error_q <= 1'b0;
          code_q <= '0;
          eidx_q <= '0;
          busy_q <= 1'b1;
          state_q <= FETCH;
        end
        FETCH: begin
          op_q <= f_op;
          addr_q <= addr_t[idx_q];
          data_q <= f_data;
          mask_q <= mask_t[idx_q];
          cnt_q <= f_data;
          att_q <= CNT_W'(1);
          if (f_op inside {OP_WR, OP_RD, OP_POLL}) begin
            write_q <= f_op == OP_WR;
            read_q <= f_op != OP_WR;
            state_q <= ISSUE;
          end else if (f_op != OP_DLY) state_q <= FINISH;
          else if (f_data != 32'd0) state_q <= DELAY;
          else begin
            state_q <= stop ? FINISH : FETCH;
            idx_q <= stop ? idx_q : idx_q + 1'b1;
          end
        end
        ISSUE: state_q <= ARM;
        ARM: state_q <= WAIT;
        WAIT: if (idle_ok) begin
          if (!is_wr) rlast_q <= amci.AMCI_RDATA;
          if (fail && !error_q) begin
            error_q <= 1'b1;
            code_q <= timeout ? 2'd3 : is_wr ? 2'd1 : 2'd2;
            eidx_q <= idx_q;
          end
          if (retry) begin
            read_q <= 1'b1;
            att_q <= att_q + 1'b1;
            state_q <= ISSUE;
          end else begin
            state_q <= stop ? FINISH : FETCH;
            idx_q <= stop ? idx_q : idx_q + 1'b1;
          end
        end
        DELAY: if (cnt_q == 32'd1) begin
          state_q <= stop ? FINISH : FETCH;
          idx_q <= stop ? idx_q : idx_q + 1'b1;
        end else cnt_q <= cnt_q - 32'd1;
        FINISH: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  assign err_code = code_q;
  assign err_idx = eidx_q;
  assign rdata_last = rlast_q;
  assign amci.AMCI_WADDR = addr_q;
  assign amci.AMCI_WDATA = data_q;
  assign amci.AMCI_WRITE = write_q;
  assign amci.AMCI_RADDR = addr_q;
  assign amci.AMCI_READ = read_q;
endmodule

// File: tb/tb_amci_cmd_sequencer.sv
// tb_amci_cmd_sequencer: directed bench; two sequencers (STOP_ERR=1 and 0) share controls, each with its own AMCI slave model
module tb_amci_cmd_sequencer;
  logic clk, reset, start, load_en, clr, echo;
  logic [3:0] load_idx;
  logic [2:0] load_op;
  logic [31:0] load_addr, load_data, load_mask, rd_val, since;
  logic [7:0] miss_n, rd_err_at, wr_err_at;
  int n_cmp = 0;
  int n_bad = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) since <= clr ? 32'd1 : since + 32'd1;
  for (genvar g = 0; g < 2; g++) begin : sl
    amci_cmd_sequencer_if bus();
    logic busy, done, error, pw, pr;
    logic [1:0] err_code;
    logic [3:0] err_idx;
    logic [31:0] rdata_last, wlast, wa_last, ra_last, ws0, ws1;
    logic [7:0] wcnt, rcnt, dcnt, bad;
    logic [2:0] wl, rl;
    amci_cmd_sequencer #(.DEPTH(16), .POLL_MAX(5), .STOP_ERR(g == 0 ? 1 : 0)) dut (
      .clk(clk), .reset(reset), .start(start), .load_en(load_en), .load_idx(load_idx),
      .load_op(load_op), .load_addr(load_addr), .load_data(load_data), .load_mask(load_mask),
      .busy(busy), .done(done), .error(error), .err_code(err_code), .err_idx(err_idx),
      .rdata_last(rdata_last), .amci(bus)
    );
    always @(posedge clk) begin
      if (reset) begin
        bus.AMCI_WIDLE <= 1'b1;
        bus.AMCI_RIDLE <= 1'b1;
        bus.AMCI_WRESP <= 2'b00;
        bus.AMCI_RRESP <= 2'b00;
        bus.AMCI_RDATA <= 32'd0;
        wl <= 3'd0;
        rl <= 3'd0;
        wcnt <= 8'd0;
        rcnt <= 8'd0;
        dcnt <= 8'd0;
        bad <= 8'd0;
        pw <= 1'b0;
        pr <= 1'b0;
        wlast <= 32'd0;
      end else begin
        if (bus.AMCI_WRITE) begin
          bus.AMCI_WIDLE <= 1'b0;
          wl <= 3'd3;
        end else if (wl != 3'd0) begin
          wl <= wl - 3'd1;
          if (wl == 3'd1) begin
            bus.AMCI_WIDLE <= 1'b1;
            bus.AMCI_WRESP <= (wcnt == wr_err_at) ? 2'b10 : 2'b00;
          end
        end
        if (bus.AMCI_READ) begin
          bus.AMCI_RIDLE <= 1'b0;
          rl <= 3'd3;
        end else if (rl != 3'd0) begin
          rl <= rl - 3'd1;
          if (rl == 3'd1) begin
            bus.AMCI_RIDLE <= 1'b1;
            bus.AMCI_RRESP <= (rcnt == rd_err_at) ? 2'b10 : 2'b00;
            bus.AMCI_RDATA <= (rcnt <= miss_n) ? 32'd0 : echo ? wlast : rd_val;
          end
        end
        pw <= bus.AMCI_WRITE;
        pr <= bus.AMCI_READ;
        if (clr) begin
          wcnt <= 8'd0;
          rcnt <= 8'd0;
          dcnt <= 8'd0;
        end else begin
          if (bus.AMCI_WRITE) begin
            wcnt <= wcnt + 8'd1;
            wlast <= bus.AMCI_WDATA;
            wa_last <= bus.AMCI_WADDR;
            if (wcnt == 8'd0) ws0 <= since;
            if (wcnt == 8'd1) ws1 <= since;
          end
          if (bus.AMCI_READ) begin
            rcnt <= rcnt + 8'd1;
            ra_last <= bus.AMCI_RADDR;
          end
          if (done) dcnt <= dcnt + 8'd1;
        end
        if ((bus.AMCI_WRITE && bus.AMCI_READ) || (pw && bus.AMCI_WRITE) || (pr && bus.AMCI_READ)) bad <= bad + 8'd1;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic load(input logic [3:0] i, input logic [2:0] op, input logic [31:0] a, d, m);
    @(negedge clk);
    load_en = 1'b1;
    load_idx = i;
    load_op = op;
    load_addr = a;
    load_data = d;
    load_mask = m;
    @(negedge clk);
    load_en = 1'b0;
  endtask
  task automatic run();
    @(negedge clk);
    clr = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while ((sl[0].dcnt == 8'd0 || sl[1].dcnt == 8'd0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(n < 600), 32'd1);
    repeat (4) @(negedge clk);
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    load_en = 1'b0;
    clr = 1'b0;
    echo = 1'b0;
    load_idx = '0;
    load_op = '0;
    load_addr = '0;
    load_data = '0;
    load_mask = '0;
    rd_val = '0;
    miss_n = '0;
    rd_err_at = '0;
    wr_err_at = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", sl[0].busy, 0);
    chk("rst_done", sl[0].done, 0);
    chk("rst_error", sl[0].error, 0);
    chk("rst_code", sl[0].err_code, 0);
    chk("rst_eidx", sl[0].err_idx, 0);
    chk("rst_rdata", sl[0].rdata_last, 0);
    chk("rst_write", sl[0].bus.AMCI_WRITE, 0);
    chk("rst_read", sl[0].bus.AMCI_READ, 0);
    chk("rst_waddr", sl[0].bus.AMCI_WADDR, 0);
    echo = 1'b1;
    load(0, 3'd1, 32'h104, 32'hA5, 0);
    load(1, 3'd2, 32'h104, 0, 0);
    load(2, 3'd0, 0, 0, 0);
    run();
    wait_done();
    chk("t1_wcnt", sl[0].wcnt, 1);
    chk("t1_waddr", sl[0].wa_last, 32'h104);
    chk("t1_wdata", sl[0].wlast, 32'hA5);
    chk("t1_rcnt", sl[0].rcnt, 1);
    chk("t1_raddr", sl[0].ra_last, 32'h104);
    chk("t1_rdata_last", sl[0].rdata_last, 32'hA5);
    chk("t1_dcnt", sl[0].dcnt, 1);
    chk("t1_error", sl[0].error, 0);
    chk("t1_latency", sl[0].ws0, 2);
    chk("t1_busy", sl[0].busy, 0);
    echo = 1'b0;
    rd_val = 32'h180;
    miss_n = 8'd3;
    load(0, 3'd3, 32'h100, 32'h80, 32'h80);
    load(1, 3'd0, 0, 0, 0);
    run();
    wait_done();
    chk("t2_reads", sl[0].rcnt, 4);
    chk("t2_raddr", sl[0].ra_last, 32'h100);
    chk("t2_error", sl[0].error, 0);
    chk("t2_rdata_last", sl[0].rdata_last, 32'h180);
    chk("t2_dcnt", sl[0].dcnt, 1);
    rd_val = 32'h7F;
    miss_n = 8'd0;
    load(0, 3'd1, 32'h10, 1, 0);
    load(1, 3'd3, 32'h100, 32'h80, 32'h80);
    load(2, 3'd0, 0, 0, 0);
    run();
    wait_done();
    chk("t3_reads", sl[0].rcnt, 5);
    chk("t3_error", sl[0].error, 1);
    chk("t3_code", sl[0].err_code, 3);
    chk("t3_eidx", sl[0].err_idx, 1);
    chk("t3_dcnt", sl[0].dcnt, 1);
    chk("t3_reads_ns", sl[1].rcnt, 5);
    chk("t3_code_ns", sl[1].err_code, 3);
    rd_val = 32'h0;
    rd_err_at = 8'd1;
    wr_err_at = 8'd2;
    load(0, 3'd1, 32'h10, 1, 0);
    load(1, 3'd2, 32'h20, 0, 0);
    load(2, 3'd1, 32'h30, 2, 0);
    load(3, 3'd0, 0, 0, 0);
    run();
    wait_done();
    chk("t4s_wcnt", sl[0].wcnt, 1);
    chk("t4s_error", sl[0].error, 1);
    chk("t4s_code", sl[0].err_code, 2);
    chk("t4s_eidx", sl[0].err_idx, 1);
    chk("t4s_dcnt", sl[0].dcnt, 1);
    chk("t4c_wcnt", sl[1].wcnt, 2);
    chk("t4c_waddr", sl[1].wa_last, 32'h30);
    chk("t4c_error", sl[1].error, 1);
    chk("t4c_code", sl[1].err_code, 2);
    chk("t4c_eidx", sl[1].err_idx, 1);
    chk("t4c_dcnt", sl[1].dcnt, 1);
    rd_err_at = 8'd0;
    wr_err_at = 8'd0;
    load(0, 3'd1, 32'h40, 1, 0);
    load(1, 3'd4, 0, 10, 0);
    load(2, 3'd1, 32'h44, 2, 0);
    load(3, 3'd0, 0, 0, 0);
    run();
    wait_done();
    chk("t5_wcnt", sl[0].wcnt, 2);
    chk("t5_gap10", sl[0].ws1 - sl[0].ws0, 17);
    chk("t5_error", sl[0].error, 0);
    load(1, 3'd4, 0, 0, 0);
    run();
    wait_done();
    chk("t5_gap0", sl[0].ws1 - sl[0].ws0, 7);
    for (int i = 0; i < 16; i++) load(4'(i), 3'd1, 32'h200 + 32'(4 * i), 32'(i), 0);
    run();
    repeat (10) @(negedge clk);
    start = 1'b1;
    load_en = 1'b1;
    load_idx = 4'd15;
    load_op = 3'd0;
    @(negedge clk);
    start = 1'b0;
    load_en = 1'b0;
    wait_done();
    chk("t6_wcnt", sl[0].wcnt, 16);
    chk("t6_waddr", sl[0].wa_last, 32'h23C);
    chk("t6_wdata", sl[0].wlast, 15);
    chk("t6_dcnt", sl[0].dcnt, 1);
    chk("t6_wcnt_ns", sl[1].wcnt, 16);
    repeat (20) @(negedge clk);
    chk("t6_nowrap", sl[0].wcnt, 16);
    chk("t6_busy", sl[0].busy, 0);
    chk("t6_dcnt_hold", sl[0].dcnt, 1);
    load(0, 3'd1, 32'h50, 5, 0);
    load(1, 3'd0, 0, 0, 0);
    run();
    repeat (3) @(negedge clk);
    chk("t7_inflight_busy", sl[0].busy, 1);
    chk("t7_inflight_wcnt", sl[0].wcnt, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t7_busy", sl[0].busy, 0);
    chk("t7_busy_ns", sl[1].busy, 0);
    chk("t7_write", sl[0].bus.AMCI_WRITE, 0);
    repeat (20) @(negedge clk);
    chk("t7_no_done", sl[0].dcnt, 0);
    chk("t7_no_done_ns", sl[1].dcnt, 0);
    chk("t7_no_write", sl[0].wcnt, 0);
    chk("strobe_rule", sl[0].bad, 0);
    chk("strobe_rule_ns", sl[1].bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
